// File: rtl/hdmi_phy_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hdmi_pkg
// Brief    : Shared TMDS constants and PHY sequencer state type.
// Revision : 1.0 - initial release
// ============================================================================
package hdmi_pkg;

    localparam int TMDS_W = 10;

    localparam logic [TMDS_W-1:0] CTRL_TOKEN_00 = 10'b1101010100;
    localparam logic [TMDS_W-1:0] CTRL_TOKEN_01 = 10'b0010101011;
    localparam logic [TMDS_W-1:0] CTRL_TOKEN_10 = 10'b0101010100;
    localparam logic [TMDS_W-1:0] CTRL_TOKEN_11 = 10'b1010101011;

    typedef enum logic [1:0] {
        LOCK_WAIT  = 2'd0,
        SERDES_RST = 2'd1,
        WARMUP     = 2'd2,
        RUN        = 2'd3
    } phy_ctrl_state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hdmi_phy_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : hdmi_phy_ctrl_if
// Brief    : Lock/control inputs, TMDS lanes and status of the PHY sequencer.
// Revision : 1.0 - initial release
// ============================================================================
interface hdmi_phy_ctrl_if
    import hdmi_pkg::*;
#(
    parameter int LOSS_CNT_W = 8
);

    logic                  pll_lock_i;
    logic                  restart_i;
    logic                  video_en_i;
    logic [TMDS_W-1:0]     tmds_red_i;
    logic [TMDS_W-1:0]     tmds_green_i;
    logic [TMDS_W-1:0]     tmds_blue_i;
    logic                  serdes_rst_o;
    logic [TMDS_W-1:0]     tmds_red_o;
    logic [TMDS_W-1:0]     tmds_green_o;
    logic [TMDS_W-1:0]     tmds_blue_o;
    logic                  phy_ready_o;
    logic [LOSS_CNT_W-1:0] lock_loss_cnt_o;

    modport master (
        output pll_lock_i, restart_i, video_en_i,
        output tmds_red_i, tmds_green_i, tmds_blue_i,
        input  serdes_rst_o, tmds_red_o, tmds_green_o, tmds_blue_o,
        input  phy_ready_o, lock_loss_cnt_o
    );

    modport slave (
        input  pll_lock_i, restart_i, video_en_i,
        input  tmds_red_i, tmds_green_i, tmds_blue_i,
        output serdes_rst_o, tmds_red_o, tmds_green_o, tmds_blue_o,
        output phy_ready_o, lock_loss_cnt_o
    );

endinterface
`default_nettype wire

// File: rtl/hdmi_phy_ctrl_sync_2ff.sv
`default_nettype none
// ============================================================================
// Module   : sync_2ff
// Brief    : Single-bit two-flop synchroniser, flops reset to 0.
// Revision : 1.0 - initial release
// ============================================================================
module sync_2ff (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_d,
    output logic      o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule
`default_nettype wire

// File: rtl/hdmi_phy_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hdmi_phy_ctrl
// Brief    : TMDS PHY startup/recovery sequencer in the pixel clock domain.
// Revision : 1.0 - initial release
// ============================================================================
module hdmi_phy_ctrl
    import hdmi_pkg::*;
#(
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int SERDES_RST_CYCLES  = 16,
    parameter int WARMUP_CYCLES      = 64,
    parameter int LOSS_CNT_W         = 8
) (
    input  wire logic       px_clk_i,
    input  wire logic       rst_i,
    hdmi_phy_ctrl_if.slave  phy
);

    localparam int c_CNT_W =
        $clog2(max3(LOCK_STABLE_CYCLES, SERDES_RST_CYCLES, WARMUP_CYCLES)) + 1;
    localparam logic [c_CNT_W-1:0] c_LOCK_LAST = c_CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_SRST_LAST = c_CNT_W'(SERDES_RST_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_WARM_LAST = c_CNT_W'(WARMUP_CYCLES - 1);

    phy_ctrl_state_t       r_state;
    phy_ctrl_state_t       w_state_nxt;
    logic [c_CNT_W-1:0]    r_cnt;
    logic [c_CNT_W-1:0]    w_cnt_nxt;
    logic [LOSS_CNT_W-1:0] r_loss_cnt;
    logic                  r_serdes_rst;
    logic                  r_phy_ready;
    logic [TMDS_W-1:0]     r_tmds_red;
    logic [TMDS_W-1:0]     r_tmds_green;
    logic [TMDS_W-1:0]     r_tmds_blue;
    logic                  w_lock_s;
    logic                  w_lost;
    logic                  w_pass;

    sync_2ff u_lock_sync (
        .clk (px_clk_i),
        .rst (rst_i),
        .i_d (phy.pll_lock_i),
        .o_q (w_lock_s)
    );

    // Lock loss is tested before restart so it wins when both occur together.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + 1'b1;
        w_lost      = 1'b0;
        case (r_state)
            LOCK_WAIT: begin
                if (!w_lock_s) begin
                    w_cnt_nxt = '0;
                end else if (r_cnt == c_LOCK_LAST) begin
                    w_state_nxt = SERDES_RST;
                    w_cnt_nxt   = '0;
                end
            end
            SERDES_RST: begin
                if (!w_lock_s) begin
                    w_state_nxt = LOCK_WAIT;
                    w_cnt_nxt   = '0;
                    w_lost      = 1'b1;
                end else if (r_cnt == c_SRST_LAST) begin
                    w_state_nxt = WARMUP;
                    w_cnt_nxt   = '0;
                end
            end
            WARMUP: begin
                if (!w_lock_s) begin
                    w_state_nxt = LOCK_WAIT;
                    w_cnt_nxt   = '0;
                    w_lost      = 1'b1;
                end else if (phy.restart_i) begin
                    w_state_nxt = SERDES_RST;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == c_WARM_LAST) begin
                    w_state_nxt = RUN;
                    w_cnt_nxt   = '0;
                end
            end
            RUN: begin
                w_cnt_nxt = r_cnt;
                if (!w_lock_s) begin
                    w_state_nxt = LOCK_WAIT;
                    w_cnt_nxt   = '0;
                    w_lost      = 1'b1;
                end else if (phy.restart_i) begin
                    w_state_nxt = SERDES_RST;
                    w_cnt_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = LOCK_WAIT;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign w_pass = (w_state_nxt == RUN) && phy.video_en_i;

    // Outputs are decoded from the next state so they line up with r_state.
    always_ff @(posedge px_clk_i) begin
        if (rst_i) begin
            r_state      <= LOCK_WAIT;
            r_cnt        <= '0;
            r_loss_cnt   <= '0;
            r_serdes_rst <= 1'b1;
            r_phy_ready  <= 1'b0;
            r_tmds_red   <= CTRL_TOKEN_00;
            r_tmds_green <= CTRL_TOKEN_00;
            r_tmds_blue  <= CTRL_TOKEN_00;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            if (w_lost && !(&r_loss_cnt)) begin
                r_loss_cnt <= r_loss_cnt + 1'b1;
            end
            r_serdes_rst <= (w_state_nxt == LOCK_WAIT) || (w_state_nxt == SERDES_RST);
            r_phy_ready  <= (w_state_nxt == RUN);
            r_tmds_red   <= w_pass ? phy.tmds_red_i   : CTRL_TOKEN_00;
            r_tmds_green <= w_pass ? phy.tmds_green_i : CTRL_TOKEN_00;
            r_tmds_blue  <= w_pass ? phy.tmds_blue_i  : CTRL_TOKEN_00;
        end
    end

    assign phy.serdes_rst_o    = r_serdes_rst;
    assign phy.phy_ready_o     = r_phy_ready;
    assign phy.tmds_red_o      = r_tmds_red;
    assign phy.tmds_green_o    = r_tmds_green;
    assign phy.tmds_blue_o     = r_tmds_blue;
    assign phy.lock_loss_cnt_o = r_loss_cnt;

endmodule
`default_nettype wire

// File: tb/tb_hdmi_phy_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_hdmi_phy_ctrl
// Brief    : Self-checking bench for the TMDS PHY startup sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hdmi_phy_ctrl;
    import hdmi_pkg::*;

    localparam int c_LOCK = 8;
    localparam int c_SRST = 4;
    localparam int c_WARM = 6;
    localparam int c_SYNC = 2;
    localparam logic [9:0] c_CTRL = 10'b1101010100;

    typedef struct packed {
        logic [9:0] r;
        logic [9:0] g;
        logic [9:0] b;
    } lanes_t;

    logic   clk = 1'b0;
    logic   rst = 1'b1;
    int     total = 0;
    int     bad = 0;
    int     exp_loss = 0;
    lanes_t sb_q[$];

    hdmi_phy_ctrl_if #(.LOSS_CNT_W(8)) phy ();

    hdmi_phy_ctrl #(
        .LOCK_STABLE_CYCLES (c_LOCK),
        .SERDES_RST_CYCLES  (c_SRST),
        .WARMUP_CYCLES      (c_WARM),
        .LOSS_CNT_W         (8)
    ) dut (
        .px_clk_i (clk),
        .rst_i    (rst),
        .phy      (phy.slave)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset;
        rst              = 1'b1;
        phy.pll_lock_i   = 1'b0;
        phy.restart_i    = 1'b0;
        phy.video_en_i   = 1'b0;
        phy.tmds_red_i   = '0;
        phy.tmds_green_i = '0;
        phy.tmds_blue_i  = '0;
        repeat (2) tick();
        rst      = 1'b0;
        exp_loss = 0;
    endtask

    // Raise lock and wait for phy_ready_o, bounded.
    task automatic go_run;
        int n;
        phy.pll_lock_i = 1'b1;
        n = 0;
        while (phy.phy_ready_o !== 1'b1 && n < 60) begin
            tick();
            n++;
        end
        if (phy.phy_ready_o !== 1'b1) begin
            bad++;
            $display("FAIL go_run: phy_ready_o=%b after %0d cycles, required 1", phy.phy_ready_o, n);
        end
    endtask

    // Counts cycles after a stimulus until serdes_rst_o falls and phy_ready_o rises.
    task automatic measure(output int fall, output int rise, output int ctrl_err);
        fall = -1;
        rise = -1;
        ctrl_err = 0;
        for (int t = 1; t <= 40 && rise < 0; t++) begin
            tick();
            if (phy.tmds_red_o !== c_CTRL || phy.tmds_green_o !== c_CTRL || phy.tmds_blue_o !== c_CTRL)
                ctrl_err++;
            if (fall < 0 && phy.serdes_rst_o === 1'b0) fall = t;
            if (rise < 0 && phy.phy_ready_o === 1'b1) rise = t;
        end
    endtask

    task automatic test_reset;
        apply_reset();
        rst = 1'b1;
        tick();
        total++;
        if (phy.serdes_rst_o !== 1'b1 || phy.phy_ready_o !== 1'b0 || phy.lock_loss_cnt_o !== 8'd0 ||
            phy.tmds_red_o !== c_CTRL || phy.tmds_green_o !== c_CTRL || phy.tmds_blue_o !== c_CTRL) begin
            bad++;
            $display("FAIL reset: srst=%b rdy=%b cnt=%0d r=%h g=%h b=%h, required 1 0 0 %h", phy.serdes_rst_o,
                     phy.phy_ready_o, phy.lock_loss_cnt_o, phy.tmds_red_o, phy.tmds_green_o, phy.tmds_blue_o, c_CTRL);
        end
        rst = 1'b0;
    endtask

    task automatic test_cold_start;
        int fall, rise, ctrl_err;
        apply_reset();
        phy.pll_lock_i = 1'b1;
        measure(fall, rise, ctrl_err);
        total++;
        if (fall !== c_SYNC + c_LOCK + c_SRST) begin
            bad++;
            $display("FAIL cold_fall: serdes_rst_o fell at cycle %0d, required %0d", fall, c_SYNC + c_LOCK + c_SRST);
        end
        total++;
        if (rise !== c_SYNC + c_LOCK + c_SRST + c_WARM) begin
            bad++;
            $display("FAIL cold_rise: phy_ready_o rose at cycle %0d, required %0d", rise, c_SYNC + c_LOCK + c_SRST + c_WARM);
        end
        total++;
        if (ctrl_err !== 0) begin
            bad++;
            $display("FAIL cold_tokens: %0d cycles without control token, required 0", ctrl_err);
        end
    endtask

    task automatic test_lock_glitch;
        int fall, rise, ctrl_err;
        apply_reset();
        phy.pll_lock_i = 1'b1;
        repeat (5) tick();
        phy.pll_lock_i = 1'b0;
        tick();
        phy.pll_lock_i = 1'b1;
        measure(fall, rise, ctrl_err);
        total++;
        if (fall !== c_SYNC + c_LOCK + c_SRST) begin
            bad++;
            $display("FAIL glitch_fall: serdes_rst_o fell at cycle %0d after re-rise, required %0d", fall, c_SYNC + c_LOCK + c_SRST);
        end
        total++;
        if (phy.lock_loss_cnt_o !== 8'd0) begin
            bad++;
            $display("FAIL glitch_cnt: lock_loss_cnt_o=%0d, required 0", phy.lock_loss_cnt_o);
        end
    endtask

    task automatic test_passthrough;
        lanes_t stim [6];
        bit     en   [6];
        lanes_t exp_w;
        lanes_t got;
        stim[0] = {10'h2AA, 10'h155, 10'h3F0}; en[0] = 1'b1;
        stim[1] = {10'h001, 10'h3FF, 10'h200}; en[1] = 1'b1;
        stim[2] = {10'($urandom), 10'($urandom), 10'($urandom)}; en[2] = 1'b1;
        stim[3] = {10'h2AA, 10'h155, 10'h3F0}; en[3] = 1'b0;
        stim[4] = {10'($urandom), 10'($urandom), 10'($urandom)}; en[4] = 1'b1;
        stim[5] = {10'h0F0, 10'h30C, 10'h111}; en[5] = 1'b0;
        for (int i = 0; i < 6; i++) begin
            phy.tmds_red_i   = stim[i].r;
            phy.tmds_green_i = stim[i].g;
            phy.tmds_blue_i  = stim[i].b;
            phy.video_en_i   = en[i];
            sb_q.push_back(en[i] ? stim[i] : lanes_t'({c_CTRL, c_CTRL, c_CTRL}));
            tick();
            exp_w = sb_q.pop_front();
            got   = {phy.tmds_red_o, phy.tmds_green_o, phy.tmds_blue_o};
            total++;
            if (got !== exp_w) begin
                bad++;
                $display("FAIL pass_%0d: lanes r=%h g=%h b=%h, required r=%h g=%h b=%h", i,
                         got.r, got.g, got.b, exp_w.r, exp_w.g, exp_w.b);
            end
        end
        phy.video_en_i = 1'b0;
    endtask

    task automatic drop_lock_and_check(input bit verbose);
        phy.pll_lock_i = 1'b0;
        tick();
        tick();
        if (verbose) begin
            total++;
            if (phy.phy_ready_o !== 1'b1) begin
                bad++;
                $display("FAIL loss_early: phy_ready_o=%b two cycles after drop, required 1", phy.phy_ready_o);
            end
        end
        tick();
        exp_loss = (exp_loss < 255) ? exp_loss + 1 : 255;
        total++;
        if (phy.phy_ready_o !== 1'b0 || phy.serdes_rst_o !== 1'b1 || phy.lock_loss_cnt_o !== 8'(exp_loss)) begin
            bad++;
            $display("FAIL loss: rdy=%b srst=%b cnt=%0d, required 0 1 %0d", phy.phy_ready_o, phy.serdes_rst_o,
                     phy.lock_loss_cnt_o, exp_loss);
        end
    endtask

    task automatic test_lock_loss;
        apply_reset();
        go_run();
        test_passthrough();
        drop_lock_and_check(1'b1);
        for (int i = 1; i < 256; i++) begin
            go_run();
            drop_lock_and_check(1'b0);
        end
    endtask

    task automatic test_restart;
        int fall, rise, ctrl_err;
        apply_reset();
        go_run();
        phy.restart_i = 1'b1;
        measure(fall, rise, ctrl_err);
        total++;
        if (fall !== c_SRST + 1) begin
            bad++;
            $display("FAIL restart_fall: serdes_rst_o fell at cycle %0d, required %0d", fall, c_SRST + 1);
        end
        total++;
        if (rise !== c_SRST + 1 + c_WARM) begin
            bad++;
            $display("FAIL restart_rise: phy_ready_o rose at cycle %0d, required %0d", rise, c_SRST + 1 + c_WARM);
        end
        total++;
        if (phy.lock_loss_cnt_o !== 8'(exp_loss)) begin
            bad++;
            $display("FAIL restart_cnt: lock_loss_cnt_o=%0d, required %0d", phy.lock_loss_cnt_o, exp_loss);
        end
    endtask

    // measure() leaves restart_i high only for the first sampled edge.
    always @(posedge clk) if (phy.restart_i === 1'b1) #2 phy.restart_i = 1'b0;

    task automatic test_restart_and_loss;
        phy.pll_lock_i = 1'b0;
        tick();
        tick();
        phy.restart_i = 1'b1;
        tick();
        exp_loss++;
        total++;
        if (phy.lock_loss_cnt_o !== 8'(exp_loss) || phy.serdes_rst_o !== 1'b1 || phy.phy_ready_o !== 1'b0) begin
            bad++;
            $display("FAIL both_now: cnt=%0d srst=%b rdy=%b, required %0d 1 0", phy.lock_loss_cnt_o,
                     phy.serdes_rst_o, phy.phy_ready_o, exp_loss);
        end
        repeat (c_SRST + 2) tick();
        total++;
        if (phy.serdes_rst_o !== 1'b1 || phy.lock_loss_cnt_o !== 8'(exp_loss)) begin
            bad++;
            $display("FAIL both_hold: srst=%b cnt=%0d, required 1 %0d", phy.serdes_rst_o, phy.lock_loss_cnt_o, exp_loss);
        end
    endtask

    task automatic test_rst_midway;
        int n;
        int fall, rise, ctrl_err;
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            go_run();
            drop_lock_and_check(1'b0);
        end
        phy.pll_lock_i = 1'b1;
        n = 0;
        while (phy.serdes_rst_o !== 1'b0 && n < 40) begin
            tick();
            n++;
        end
        tick();
        total++;
        if (phy.serdes_rst_o !== 1'b0 || phy.phy_ready_o !== 1'b0 || phy.lock_loss_cnt_o !== 8'd3) begin
            bad++;
            $display("FAIL warmup_entry: srst=%b rdy=%b cnt=%0d, required 0 0 3", phy.serdes_rst_o,
                     phy.phy_ready_o, phy.lock_loss_cnt_o);
        end
        rst = 1'b1;
        tick();
        total++;
        if (phy.serdes_rst_o !== 1'b1 || phy.phy_ready_o !== 1'b0 || phy.lock_loss_cnt_o !== 8'd0 ||
            phy.tmds_red_o !== c_CTRL || phy.tmds_green_o !== c_CTRL || phy.tmds_blue_o !== c_CTRL) begin
            bad++;
            $display("FAIL mid_rst: srst=%b rdy=%b cnt=%0d r=%h, required 1 0 0 %h", phy.serdes_rst_o,
                     phy.phy_ready_o, phy.lock_loss_cnt_o, phy.tmds_red_o, c_CTRL);
        end
        rst = 1'b0;
        measure(fall, rise, ctrl_err);
        total++;
        if (fall !== c_SYNC + c_LOCK + c_SRST) begin
            bad++;
            $display("FAIL mid_rst_restart: serdes_rst_o fell at cycle %0d, required %0d", fall, c_SYNC + c_LOCK + c_SRST);
        end
    endtask

    initial begin
        test_reset();
        test_cold_start();
        test_lock_glitch();
        test_lock_loss();
        test_restart();
        test_restart_and_loss();
        test_rst_midway();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
